serialize_words_to_bit_stream: RTL
==================================

// Module: serialize_words_to_bit_stream
//
// PURPOSE
// Upstream feeder for the serial sequence detectors (4-bit "1010", 6-bit "110011").
// Accepts parallel words over a valid/ready handshake and emits them one bit per clock
// on new_bit, qualified by bit_valid.
// A one-word holding buffer lets consecutive words stream with no idle bubble between them,
// so patterns that straddle word boundaries reach the detector intact.
//
// PARAMETERS
// WIDTH      8   bits per input word (>= 2)
// MSB_FIRST  1   1: in_data[WIDTH-1] is sent first; 0: in_data[0] is sent first
// IDLE_BIT   0   value driven on new_bit while bit_valid = 0
//
// PORTS
// clk        in   1      clock, all state on rising edge
// rst        in   1      asynchronous, active-low reset
// in_valid   in   1      in_data holds a word to transfer
// in_ready   out  1      block can accept a word this cycle
// in_data    in   WIDTH  word to serialize
// new_bit    out  1      serial data bit, registered
// bit_valid  out  1      new_bit carries a word bit this cycle, registered
// last_bit   out  1      current bit is the final bit of its word, registered
// busy       out  1      shifter or holding buffer non-empty
//
// BEHAVIOUR
// - Reset (rst = 0, async):
//   - shifter and holding buffer empty, bit counter 0.
//   - new_bit = IDLE_BIT; bit_valid = last_bit = busy = 0; in_ready = 1 once rst deasserts.
//   - A word partially sent when reset asserts is discarded; no remaining bits are output.
// - Handshake:
//   - Transfer occurs on a rising edge with in_valid & in_ready.
//   - in_ready = !hold_full; it is combinational from state only, never from in_valid.
//   - in_data is sampled only on the transfer edge.
// - State: SH_IDLE / SH_SHIFT plus hold_full flag. Bit counter cnt runs 0..WIDTH-1.
// - Load rule, evaluated each edge:
//   - Shifter is free when it is in SH_IDLE, or in SH_SHIFT with cnt == WIDTH-1 (last bit on output).
//   - Shifter free and hold_full: the holding word loads into the shifter, hold_full clears.
//     An accepted word in the same edge then goes into the holding buffer.
//   - Shifter free and !hold_full: the accepted word loads straight into the shifter.
//   - Shifter busy: the accepted word goes into the holding buffer, hold_full sets.
// - Latency: a word accepted at edge N drives its first bit at edge N+1 when the shifter is free.
//   Its remaining bits follow on consecutive cycles with no gaps.
// - Streaming: back-to-back words give continuous bit_valid, with word k+1 bit 0 in the cycle
//   after word k's last_bit.
// - Each shift: cnt increments; cnt wraps WIDTH-1 -> 0 on reload.
//   - last_bit = 1 exactly when cnt == WIDTH-1 and bit_valid = 1.
// - No load at the last bit: state goes to SH_IDLE; next cycle bit_valid = 0, new_bit = IDLE_BIT.
// - busy = (state == SH_SHIFT) | hold_full.
// - Bit order follows MSB_FIRST; it is fixed per instance, no runtime switch.
//
// TESTING
// 1) WIDTH=8, MSB_FIRST=1, accept 8'b1100_1100 while idle -> bit_valid high for 8 cycles from the
//    next edge; new_bit = 1,1,0,0,1,1,0,0; last_bit only on cycle 8; then bit_valid = 0.
// 2) Accept 8'h33 then 8'h0F as early as in_ready allows -> 16 contiguous valid bits
//    0011001100001111. in_ready drops while the holding buffer is full; no word is lost or duplicated.
// 3) Hold in_valid = 1 continuously with 4 words -> bit_valid never deasserts across all 32 bits;
//    in_ready pulses once per 8 cycles.
// 4) rst low mid-word (after bit 3 of 8'hA5) -> outputs reset asynchronously.
//    After release, a new word 8'h5A serializes fully; no bits of 8'hA5 appear.
// 5) MSB_FIRST=0, accept 8'b0000_0011 -> new_bit = 1,1,0,0,0,0,0,0.
// 6) Chain into detect_6_bit_sequence_using_shift_reg (new_bit only), send 8'b0110_0110 ->
//    detected pulses exactly once, one cycle after bit index 6 (the final "1" of 110011).

Source files
------------

// File: rtl/serialize_words_to_bit_stream_if.sv
// Word handshake between an upstream producer and the bit serializer.
// The master drives words; the slave (serializer) returns in_ready.
interface serialize_words_to_bit_stream_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/serialize_words_to_bit_stream.sv
// Parallel-word to serial-bit converter with a one-word holding buffer so that
// back-to-back words stream without an idle bit between them.
module serialize_words_to_bit_stream #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic                            clk,
  input  logic                            rst,
  serialize_words_to_bit_stream_if.slave  i_word,
  output logic                            o_new_bit,
  output logic                            o_bit_valid,
  output logic                            o_last_bit,
  output logic                            o_busy
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {SH_IDLE = 1'b0, SH_SHIFT = 1'b1} sh_state_t;

  sh_state_t        r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_shift, w_shift_nxt;
  logic [WIDTH-1:0] r_hold, w_hold_nxt;
  logic             r_hold_full, w_hold_full_nxt;
  logic             r_new_bit, r_bit_valid, r_last_bit, r_busy;
  logic             w_free, w_xfer, w_load;
  logic [WIDTH-1:0] w_load_word;
  logic             w_bit_valid_nxt;

  // r_shift keeps the word aligned so its lead bit is the one currently on the line.
  function automatic logic lead_bit(input logic [WIDTH-1:0] w);
    if (MSB_FIRST) return w[WIDTH-1];
    else           return w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    if (MSB_FIRST) return {w[WIDTH-2:0], 1'b0};
    else           return {1'b0, w[WIDTH-1:1]};
  endfunction

  assign i_word.in_ready = !r_hold_full;
  assign o_new_bit       = r_new_bit;
  assign o_bit_valid     = r_bit_valid;
  assign o_last_bit      = r_last_bit;
  assign o_busy          = r_busy;

  // Next-state: load/shift/idle decision and holding-buffer bookkeeping.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_shift_nxt     = r_shift;
    w_hold_nxt      = r_hold;
    w_hold_full_nxt = r_hold_full;
    w_load          = 1'b0;
    w_load_word     = '0;
    w_free          = (r_state == SH_IDLE) || (r_cnt == LAST_CNT);
    w_xfer          = i_word.in_valid && !r_hold_full;

    if (w_free) begin
      if (r_hold_full) begin
        w_load          = 1'b1;
        w_load_word     = r_hold;
        w_hold_full_nxt = w_xfer;
        if (w_xfer) w_hold_nxt = i_word.in_data;
        else        w_hold_nxt = r_hold;
      end else if (w_xfer) begin
        w_load      = 1'b1;
        w_load_word = i_word.in_data;
      end else begin
        w_load = 1'b0;
      end
    end else begin
      if (w_xfer) begin
        w_hold_nxt      = i_word.in_data;
        w_hold_full_nxt = 1'b1;
      end else begin
        w_hold_full_nxt = r_hold_full;
      end
    end

    if (w_load) begin
      w_state_nxt = SH_SHIFT;
      w_cnt_nxt   = '0;
      w_shift_nxt = w_load_word;
    end else if (w_free) begin
      w_state_nxt = SH_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      w_cnt_nxt   = r_cnt + CW'(1);
      w_shift_nxt = advance(r_shift);
    end

    w_bit_valid_nxt = (w_state_nxt == SH_SHIFT);
  end

  // State and registered outputs; reset drops any partially sent word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= SH_IDLE;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_new_bit   <= IDLE_BIT;
      r_bit_valid <= 1'b0;
      r_last_bit  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_shift     <= w_shift_nxt;
      r_hold      <= w_hold_nxt;
      r_hold_full <= w_hold_full_nxt;
      r_new_bit   <= w_bit_valid_nxt ? lead_bit(w_shift_nxt) : IDLE_BIT;
      r_bit_valid <= w_bit_valid_nxt;
      r_last_bit  <= w_bit_valid_nxt && (w_cnt_nxt == LAST_CNT);
      r_busy      <= w_bit_valid_nxt || w_hold_full_nxt;
    end
  end
endmodule
